ysyx_220066_dmem_resp: RTL

//  Memory-side responder for the CPU data port (addr/MemOp/MemRd/MemWr/data_Wr -> data_Rd/valid/error).

---
 rtl/ysyx_220066_dmem_resp.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/ysyx_220066_dmem_resp.sv
// Data-port memory responder: one load/store in flight, fixed-latency response,
// byte-lane merge on stores and lane extraction with sign/zero extension on loads.
module ysyx_220066_dmem_resp #(
  parameter logic [63:0] BASE       = 64'h8000_0000,
  parameter int          DEPTH_LOG2 = 12,
  parameter int          LAT        = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [63:0] addr,
  input  logic [2:0]  MemOp,
  input  logic [63:0] data_Wr,
  output logic        busy,
  output logic [63:0] data_Rd,
  output logic        valid,
  output logic        error
);

  // Handshake: a request is accepted on a rising edge where busy=0 and
  // MemRd|MemWr is high; the initiator holds it until then. valid pulses for
  // exactly one cycle; data_Rd/error are meaningful only while valid=1.
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  localparam logic [64:0] LIMIT = {1'b0, BASE} + (65'd8 << DEPTH_LOG2);

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n;
  logic [63:0] r_addr, r_wdata;
  logic [2:0]  r_op;
  logic        r_wr, r_fault;

  logic [63:0] mem [0:(1 << DEPTH_LOG2) - 1];

  logic        req, accept, enter_resp;
  logic        fault_in, misaligned;
  logic [2:0]  align_mask;
  logic [63:0] cur_addr, cur_wdata, cur_off;
  logic [2:0]  cur_op, lane;
  logic        cur_wr, cur_fault;
  logic [DEPTH_LOG2-1:0] idx;
  logic [7:0]  size_mask, byte_en;
  logic [63:0] wshift, rshift, load_val;

  assign req    = MemRd | MemWr;
  assign accept = (state == IDLE) && req;
  assign busy   = (state != IDLE);
  assign valid  = (state == RESP);

  always_comb begin
    align_mask = 3'b000;
    case (MemOp[1:0])
      2'd1:    align_mask = 3'b001;
      2'd2:    align_mask = 3'b011;
      2'd3:    align_mask = 3'b111;
      default: align_mask = 3'b000;
    endcase
    misaligned = |(addr[2:0] & align_mask);
    fault_in = ({1'b0, addr} < {1'b0, BASE}) || ({1'b0, addr} >= LIMIT) ||
               misaligned || (MemOp == 3'b111) || (MemWr && MemOp[2]) ||
               (MemRd && MemWr);
  end

  // With LAT=1 the edge entering RESP is the accept edge, so the live inputs
  // stand in for the latched request.
  always_comb begin
    if (state == IDLE) begin
      cur_addr  = addr;
      cur_wdata = data_Wr;
      cur_op    = MemOp;
      cur_wr    = MemWr;
      cur_fault = fault_in;
    end else begin
      cur_addr  = r_addr;
      cur_wdata = r_wdata;
      cur_op    = r_op;
      cur_wr    = r_wr;
      cur_fault = r_fault;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (req) begin
          cnt_n   = 4'(LAT - 1);
          state_n = (LAT == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_n = cnt - 4'd1;
        if (cnt <= 4'd1) state_n = RESP;
      end
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign enter_resp = (state_n == RESP) && (state != RESP);

  always_comb begin
    cur_off = cur_addr - BASE;
    idx     = DEPTH_LOG2'(cur_off >> 3);
    lane    = cur_addr[2:0];
    case (cur_op[1:0])
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
    byte_en = size_mask << lane;
    wshift  = cur_wdata << {lane, 3'b000};
    rshift  = mem[idx] >> {lane, 3'b000};
    case (cur_op)
      3'b000:  load_val = {{56{rshift[7]}}, rshift[7:0]};
      3'b001:  load_val = {{48{rshift[15]}}, rshift[15:0]};
      3'b010:  load_val = {{32{rshift[31]}}, rshift[31:0]};
      3'b011:  load_val = rshift;
      3'b100:  load_val = {56'd0, rshift[7:0]};
      3'b101:  load_val = {48'd0, rshift[15:0]};
      3'b110:  load_val = {32'd0, rshift[31:0]};
      default: load_val = 64'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      r_addr  <= 64'd0;
      r_wdata <= 64'd0;
      r_op    <= 3'd0;
      r_wr    <= 1'b0;
      r_fault <= 1'b0;
      data_Rd <= 64'd0;
      error   <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        r_addr  <= addr;
        r_wdata <= data_Wr;
        r_op    <= MemOp;
        r_wr    <= MemWr;
        r_fault <= fault_in;
      end
      if (enter_resp) begin
        data_Rd <= (cur_fault || cur_wr) ? 64'd0 : load_val;
        error   <= cur_fault;
      end
    end
  end

  // SRAM is not reset; rst gates the write so a dropped store never lands.
  always_ff @(posedge clk) begin
    if (rst && enter_resp && cur_wr && !cur_fault) begin
      for (int b = 0; b < 8; b++) begin
        if (byte_en[b]) mem[idx][8*b +: 8] <= wshift[8*b +: 8];
      end
    end
  end

endmodule
